// File: rtl/cardinal_input_port.sv
// Cardinal ring router input channel: two one-entry VC buffers swapped by polarity,
// hop-based route request towards PE / clockwise / counter-clockwise outputs.
module cardinal_input_port #(
    parameter int PACKET_SIZE = 64,
    parameter int HOP_MSB     = 8,
    parameter int HOP_LSB     = 15
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   polarity,
    input  logic                   si,
    output logic                   ri,
    input  logic [0:PACKET_SIZE-1] di,
    output logic                   req_local,
    output logic                   req_cw,
    output logic                   req_ccw,
    input  logic                   gnt_local,
    input  logic                   gnt_cw,
    input  logic                   gnt_ccw,
    output logic [0:PACKET_SIZE-1] dout,
    output logic                   vc_err
);

    localparam int HOP_W = HOP_LSB - HOP_MSB + 1;

    logic [0:PACKET_SIZE-1] pkt0, pkt1;
    logic                   full0, full1;

    logic                   ext_vc, int_vc;
    logic [0:PACKET_SIZE-1] pkt_hold;
    logic                   hold_valid;
    logic [HOP_W-1:0]       hop;
    logic                   hop_zero;
    logic                   req_any;
    logic                   grant;
    logic [0:PACKET_SIZE-1] pkt_dec;

    // polarity==1 exposes the even buffer upstream while the odd one drives the outputs
    assign ext_vc = ~polarity;
    assign int_vc = polarity;

    assign ri         = reset & ~(ext_vc ? full1 : full0);
    assign pkt_hold   = int_vc ? pkt1 : pkt0;
    assign hold_valid = reset & (int_vc ? full1 : full0);
    assign hop        = pkt_hold[HOP_MSB:HOP_LSB];
    assign hop_zero   = (hop == '0);

    assign req_local = hold_valid & hop_zero;
    assign req_cw    = hold_valid & ~hop_zero & ~pkt_hold[1];
    assign req_ccw   = hold_valid & ~hop_zero &  pkt_hold[1];
    assign req_any   = req_local | req_cw | req_ccw;

    assign grant = (gnt_local & req_local) | (gnt_cw & req_cw) | (gnt_ccw & req_ccw);

    always_comb begin
        pkt_dec                  = pkt_hold;
        pkt_dec[HOP_MSB:HOP_LSB] = hop - HOP_W'(1);
        dout                     = '0;
        if (req_any) begin
            dout = hop_zero ? pkt_hold : pkt_dec;
        end
    end

    // The write targets the external buffer and the grant clears the internal one,
    // so both can happen on the same edge without interacting.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pkt0   <= '0;
            pkt1   <= '0;
            full0  <= 1'b0;
            full1  <= 1'b0;
            vc_err <= 1'b0;
        end else begin
            if (si && ri) begin
                if (ext_vc) begin
                    pkt1  <= di;
                    full1 <= 1'b1;
                end else begin
                    pkt0  <= di;
                    full0 <= 1'b1;
                end
                if (di[0] != ext_vc) begin
                    vc_err <= 1'b1;
                end
            end
            if (grant) begin
                if (int_vc) begin
                    full1 <= 1'b0;
                end else begin
                    full0 <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_cardinal_input_port.sv
// Self-checking bench for cardinal_input_port: scoreboard of expected requests/data,
// popped when the bench grants the request the DUT presents.
module tb_cardinal_input_port;

    logic        clk = 1'b0;
    logic        reset;
    logic        polarity;
    logic        si;
    logic        ri;
    logic [0:63] di;
    logic        req_local, req_cw, req_ccw;
    logic        gnt_local, gnt_cw, gnt_ccw;
    logic [0:63] dout;
    logic        vc_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]  req;   // {local, cw, ccw}
        logic [0:63] data;
    } exp_t;

    exp_t sb[$];

    cardinal_input_port #(.PACKET_SIZE(64), .HOP_MSB(8), .HOP_LSB(15)) dut (
        .clk       (clk),
        .reset     (reset),
        .polarity  (polarity),
        .si        (si),
        .ri        (ri),
        .di        (di),
        .req_local (req_local),
        .req_cw    (req_cw),
        .req_ccw   (req_ccw),
        .gnt_local (gnt_local),
        .gnt_cw    (gnt_cw),
        .gnt_ccw   (gnt_ccw),
        .dout      (dout),
        .vc_err    (vc_err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; inputs are driven 1 time unit after the edge, outputs sampled 2 later.
    task automatic tick();
        @(posedge clk);
        #1;
        polarity  = ~polarity;
        si        = 1'b0;
        gnt_local = 1'b0;
        gnt_cw    = 1'b0;
        gnt_ccw   = 1'b0;
        #2;
    endtask

    function automatic logic [0:63] make_pkt(input logic vc, input logic dir, input logic [7:0] hop);
        logic [0:63] p;
        p       = {$urandom, $urandom};
        p[0]    = vc;
        p[1]    = dir;
        p[8:15] = hop;
        return p;
    endfunction

    function automatic exp_t expect_of(input logic [0:63] p);
        exp_t e;
        e.data = p;
        if (p[8:15] == 8'd0) begin
            e.req = 3'b100;
        end else begin
            e.req       = p[1] ? 3'b001 : 3'b010;
            e.data[8:15] = p[8:15] - 8'd1;
        end
        return e;
    endfunction

    function automatic logic [2:0] req_vec();
        return {req_local, req_cw, req_ccw};
    endfunction

    task automatic inject(input logic [0:63] p);
        check_val("ri_before_send", 64'(ri), 64'd1);
        si = 1'b1;
        di = p;
        sb.push_back(expect_of(p));
    endtask

    // Compare the presented request against the scoreboard head and grant it.
    task automatic serve();
        exp_t e;
        if (sb.size() == 0) begin
            check_val("req_idle", 64'(req_vec()), 64'd0);
        end else begin
            e = sb.pop_front();
            check_val("req_kind", 64'(req_vec()), 64'(e.req));
            check_val("dout", dout, e.data);
            gnt_local = e.req[2];
            gnt_cw    = e.req[1];
            gnt_ccw   = e.req[0];
        end
    endtask

    // Compare against the scoreboard head without granting.
    task automatic expect_hold();
        check_val("hold_req", 64'(req_vec()), 64'(sb[0].req));
        check_val("hold_dout", dout, sb[0].data);
    endtask

    task automatic expect_quiet(input string tag);
        check_val({tag, "_req"}, 64'(req_vec()), 64'd0);
        check_val({tag, "_dout"}, dout, 64'd0);
    endtask

    logic [0:63] p;

    initial begin
        reset     = 1'b0;
        polarity  = 1'b0;
        si        = 1'b1;
        di        = '1;
        gnt_local = 1'b0;
        gnt_cw    = 1'b0;
        gnt_ccw   = 1'b0;

        // reset held with si asserted
        for (int i = 0; i < 2; i++) begin
            tick();
            si = 1'b1;
            #1;
            check_val("rst_ri", 64'(ri), 64'd0);
            expect_quiet("rst");
            check_val("rst_vc_err", 64'(vc_err), 64'd0);
        end
        tick();
        reset = 1'b1;
        #1;
        check_val("pol_after_rst", 64'(polarity), 64'd1);
        check_val("ri_after_rst", 64'(ri), 64'd1);
        expect_quiet("idle");

        // even cw packet, hop 3, granted next cycle
        inject(make_pkt(1'b0, 1'b0, 8'd3));
        tick();
        serve();
        tick();
        check_val("ri_freed", 64'(ri), 64'd1);
        expect_quiet("after_grant");

        // hop 0 with dir=1: local only, mismatched grant ignored
        p = make_pkt(1'b0, 1'b1, 8'd0);
        inject(p);
        tick();
        expect_hold();
        check_val("local_dout_raw", dout, p);
        gnt_ccw = 1'b1;
        tick();
        check_val("held_ri", 64'(ri), 64'd0);
        expect_quiet("held_off");
        tick();
        serve();
        tick();
        check_val("ri_freed2", 64'(ri), 64'd1);

        // even ccw packet left ungranted for four cycles
        inject(make_pkt(1'b0, 1'b1, 8'd5));
        for (int i = 0; i < 2; i++) begin
            tick();
            expect_hold();
            tick();
            check_val("stall_ri", 64'(ri), 64'd0);
            expect_quiet("stall_off");
        end
        tick();
        serve();
        tick();
        check_val("ri_freed3", 64'(ri), 64'd1);

        // back-to-back traffic on both VCs, granted every cycle
        for (int i = 0; i < 10; i++) begin
            if (i > 0) begin
                check_val("b2b_req_present", 64'(req_vec() != 3'b000), 64'(sb.size() > 0));
            end
            serve();
            if (i < 8) begin
                inject(make_pkt(~polarity, 1'($urandom), 8'($urandom_range(0, 3))));
            end
            tick();
        end
        expect_quiet("b2b_drained");
        check_val("b2b_vc_err", 64'(vc_err), 64'd0);

        // wrong VC bit: stored anyway, error sticky until reset
        while (polarity != 1'b1) tick();
        inject(make_pkt(1'b1, 1'b0, 8'd1));
        #1;
        check_val("vc_err_pre", 64'(vc_err), 64'd0);
        tick();
        check_val("vc_err_set", 64'(vc_err), 64'd1);
        serve();
        for (int i = 0; i < 3; i++) tick();
        check_val("vc_err_sticky", 64'(vc_err), 64'd1);
        reset = 1'b0;
        tick();
        check_val("vc_err_cleared", 64'(vc_err), 64'd0);
        check_val("rst_ri2", 64'(ri), 64'd0);
        check_val("sb_empty", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
